// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the CPU datapath.
// Steps through fetch (T0-T2) and opcode-dependent execute steps (T3-T7),
// running instructions back-to-back until a halt opcode or a Stop request.
// Ports:
//   Clock, Reset (async, active-low)   - clock and reset
//   IR[31:27]                           - opcode being executed
//   CON_FF                              - branch condition, gates PCin in br T6
//   Stop                                - halt request, honoured at instruction end
//   Run                                 - high while sequencing (not RST/HALT)
//   bus-out / register-in / select / memory strobes - datapath controls
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
  output logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
  output logic        Gra, Grb, Grc, Rin, Rout,
  output logic        Read, Write
);

  localparam int unsigned OpW   = 5;
  localparam int unsigned StepW = 3;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_UNARY, C_MULDIV, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NONE, C_HALT
  } cls_e;

  state_e             state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  logic [OpW-1:0]     opcode;
  cls_e               cls;
  logic [StepW-1:0]   last_step;
  state_e             boundary_st;
  logic               unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Opcode -> instruction class and index of its final step
  always_comb begin
    cls       = C_NONE;
    last_step = StepW'(2);
    case (opcode)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        cls = C_ALU;    last_step = StepW'(5);
      end
      5'd12, 5'd13, 5'd14: begin cls = C_IMM;    last_step = StepW'(5); end
      5'd17, 5'd18:        begin cls = C_UNARY;  last_step = StepW'(4); end
      5'd15, 5'd16:        begin cls = C_MULDIV; last_step = StepW'(6); end
      5'd1:                begin cls = C_LDI;    last_step = StepW'(5); end
      5'd0:                begin cls = C_LD;     last_step = StepW'(7); end
      5'd2:                begin cls = C_ST;     last_step = StepW'(7); end
      5'd19:               begin cls = C_BR;     last_step = StepW'(6); end
      5'd20:               begin cls = C_JR;     last_step = StepW'(3); end
      5'd22:               begin cls = C_IN;     last_step = StepW'(3); end
      5'd23:               begin cls = C_OUT;    last_step = StepW'(3); end
      5'd24:               begin cls = C_MFHI;   last_step = StepW'(3); end
      5'd25:               begin cls = C_MFLO;   last_step = StepW'(3); end
      5'd27:               begin cls = C_HALT;   last_step = StepW'(2); end
      default:             begin cls = C_NONE;   last_step = StepW'(2); end
    endcase
  end

  // State and pending-stop registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_RST;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next state; a Stop seen at any point in an instruction is held until its final step
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q | Stop;
    boundary_st = (Stop || stop_pend_q) ? S_HALT : S_T0;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (cls == C_HALT)               state_d = S_HALT;
        else if (last_step == StepW'(2)) state_d = boundary_st;
        else                             state_d = S_T3;
      end
      S_T3:   state_d = (last_step == StepW'(3)) ? boundary_st : S_T4;
      S_T4:   state_d = (last_step == StepW'(4)) ? boundary_st : S_T5;
      S_T5:   state_d = (last_step == StepW'(5)) ? boundary_st : S_T6;
      S_T6:   state_d = (last_step == StepW'(6)) ? boundary_st : S_T7;
      S_T7:   state_d = boundary_st;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Strobe decode from state and opcode class
  always_comb begin
    Run = 1'b0;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Run = (state_q != S_RST) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNARY:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_MULDIV:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_JR:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_IN:             begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:            begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          C_MFHI:           begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO:           begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:                    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
          C_UNARY:                  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MULDIV:                 begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
          C_BR:                     begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:                begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR:     begin Zlowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Compares the packed 28-bit strobe vector against hand-written step tables.
module tb_control_unit;

  logic        Clock, Reset, CON_FF, Stop;
  logic [31:0] IR;
  logic Run;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, Read, Write;

  int checks = 0;
  int failures = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
    .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Read(Read), .Write(Write)
  );

  logic [27:0] obs;
  assign obs = {Run, Read, Write, Gra, Grb, Grc, Rin, Rout,
                PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, OutPortin, CONin,
                PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout};

  localparam logic [27:0] BAOUT = 28'(1) << 0,  COUT = 28'(1) << 1,  INPORTOUT = 28'(1) << 2;
  localparam logic [27:0] LOOUT = 28'(1) << 3,  HIOUT = 28'(1) << 4, MDROUT = 28'(1) << 5;
  localparam logic [27:0] ZLOWOUT = 28'(1) << 6, ZHIGHOUT = 28'(1) << 7, PCOUT = 28'(1) << 8;
  localparam logic [27:0] CONIN = 28'(1) << 9, OUTPORTIN = 28'(1) << 10, LOIN = 28'(1) << 11;
  localparam logic [27:0] HIIN = 28'(1) << 12, ZIN = 28'(1) << 13, YIN = 28'(1) << 14;
  localparam logic [27:0] IRIN = 28'(1) << 15, MDRIN = 28'(1) << 16, MARIN = 28'(1) << 17;
  localparam logic [27:0] INCPC = 28'(1) << 18, PCIN = 28'(1) << 19, ROUT = 28'(1) << 20;
  localparam logic [27:0] RIN = 28'(1) << 21, GRC = 28'(1) << 22, GRB = 28'(1) << 23;
  localparam logic [27:0] GRA = 28'(1) << 24, WRITE = 28'(1) << 25, READ = 28'(1) << 26;
  localparam logic [27:0] RUN = 28'(1) << 27;

  localparam logic [27:0] F0 = RUN | PCOUT | MARIN | INCPC | PCIN;
  localparam logic [27:0] F1 = RUN | READ | MDRIN;
  localparam logic [27:0] F2 = RUN | MDROUT | IRIN;

  localparam logic [4:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_ADD = 5'd3, OP_MUL = 5'd15;
  localparam logic [4:0] OP_BR = 5'd19, OP_JR = 5'd20, OP_MFLO = 5'd25, OP_NOP = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  logic [27:0] exp_v [0:7];
  int          n_steps;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input logic [4:0] op);
    IR = {op, 27'h1234567};
  endtask

  task automatic fill_ld(input bit is_st);
    exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2;
    exp_v[3] = RUN | GRB | BAOUT | YIN;
    exp_v[4] = RUN | COUT | ZIN;
    exp_v[5] = RUN | ZLOWOUT | MARIN;
    exp_v[6] = is_st ? (RUN | GRA | ROUT | MDRIN) : (RUN | READ | MDRIN);
    exp_v[7] = is_st ? (RUN | WRITE) : (RUN | MDROUT | GRA | RIN);
    n_steps  = 8;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Stop = 1'b0; CON_FF = 1'b0; set_op(OP_NOP);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++;
      if (obs !== 28'h0) begin
        failures++; $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs, 28'h0);
      end
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 28'h0) begin
      failures++; $display("FAIL reset_release_pre_edge: got %h want %h", obs, 28'h0);
    end
    @(negedge Clock);
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL reset_first_t0: got %h want %h", obs, F0);
    end
  endtask

  task automatic test_add();
    set_op(OP_ADD);
    exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2;
    exp_v[3] = RUN | GRB | ROUT | YIN;
    exp_v[4] = RUN | GRC | ROUT | ZIN;
    exp_v[5] = RUN | ZLOWOUT | GRA | RIN;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL add_T%0d: got %h want %h", i, obs, exp_v[i]);
      end
      @(negedge Clock);
    end
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL add_next_t0_cycle7: got %h want %h", obs, F0);
    end
  endtask

  task automatic test_ld_st();
    for (int k = 0; k < 2; k++) begin
      set_op(k == 0 ? OP_LD : OP_ST);
      fill_ld(k == 1);
      for (int i = 0; i < n_steps; i++) begin
        checks++;
        if (obs !== exp_v[i]) begin
          failures++; $display("FAIL %s_T%0d: got %h want %h", k == 0 ? "ld" : "st", i, obs, exp_v[i]);
        end
        @(negedge Clock);
      end
    end
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL ldst_next_t0: got %h want %h", obs, F0);
    end
  endtask

  task automatic test_br();
    for (int k = 0; k < 2; k++) begin
      set_op(OP_BR);
      CON_FF = (k == 0);
      exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2;
      exp_v[3] = RUN | GRA | ROUT | CONIN;
      exp_v[4] = RUN | PCOUT | YIN;
      exp_v[5] = RUN | COUT | ZIN;
      exp_v[6] = (k == 0) ? (RUN | ZLOWOUT | PCIN) : (RUN | ZLOWOUT);
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (obs !== exp_v[i]) begin
          failures++; $display("FAIL br_con%0d_T%0d: got %h want %h", 1 - k, i, obs, exp_v[i]);
        end
        @(negedge Clock);
      end
      checks++;
      if (obs !== F0) begin
        failures++; $display("FAIL br_con%0d_next_t0: got %h want %h", 1 - k, obs, F0);
      end
    end
    CON_FF = 1'b0;
  endtask

  task automatic test_back_to_back();
    // nop (3 cycles), jr (4 cycles), mflo (4 cycles) run consecutively
    set_op(OP_NOP);
    exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL nop_T%0d: got %h want %h", i, obs, exp_v[i]);
      end
      @(negedge Clock);
    end
    for (int k = 0; k < 2; k++) begin
      set_op(k == 0 ? OP_JR : OP_MFLO);
      exp_v[3] = (k == 0) ? (RUN | GRA | ROUT | PCIN) : (RUN | LOOUT | GRA | RIN);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== exp_v[i]) begin
          failures++; $display("FAIL %s_T%0d: got %h want %h", k == 0 ? "jr" : "mflo", i, obs, exp_v[i]);
        end
        @(negedge Clock);
      end
    end
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL b2b_next_t0: got %h want %h", obs, F0);
    end
  endtask

  task automatic test_stop_mul();
    set_op(OP_MUL);
    exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2;
    exp_v[3] = RUN | GRA | ROUT | YIN;
    exp_v[4] = RUN | GRB | ROUT | ZIN;
    exp_v[5] = RUN | ZLOWOUT | LOIN;
    exp_v[6] = RUN | ZHIGHOUT | HIIN;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL stop_mul_T%0d: got %h want %h", i, obs, exp_v[i]);
      end
      Stop = (i == 4);
      @(negedge Clock);
    end
    Stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== 28'h0) begin
        failures++; $display("FAIL stop_mul_halt%0d: got %h want %h", i, obs, 28'h0);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_halt();
    do_reset();
    set_op(OP_HALT);
    exp_v[0] = F0; exp_v[1] = F1; exp_v[2] = F2; exp_v[3] = 28'h0; exp_v[4] = 28'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL halt_op_step%0d: got %h want %h", i, obs, exp_v[i]);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_op(OP_LD);
    fill_ld(1'b0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        failures++; $display("FAIL areset_ld_T%0d: got %h want %h", i, obs, exp_v[i]);
      end
      if (i < 6) @(negedge Clock);
    end
    #1 Reset = 1'b0;
    #1;
    checks++;
    if (obs !== 28'h0) begin
      failures++; $display("FAIL areset_async_clear: got %h want %h", obs, 28'h0);
    end
    @(negedge Clock);
    checks++;
    if (obs !== 28'h0) begin
      failures++; $display("FAIL areset_held: got %h want %h", obs, 28'h0);
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL areset_restart_t0: got %h want %h", obs, F0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_st();
    test_br();
    test_back_to_back();
    test_stop_mul();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
